// File: rtl/multiplier_4_bit_pkg.sv
// rtl/multiplier_4_bit_pkg.sv - shared types, widths and width helpers for the shift-add multiplier
package multiplier_4_bit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mult_state_t;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int PRODUCT_WIDTH      = 2 * DEFAULT_DATA_WIDTH;
    localparam int COUNT_WIDTH        = $clog2(DEFAULT_DATA_WIDTH + 1);

    // Product width for an arbitrary operand width
    function automatic int product_width(input int data_width);
        return 2 * data_width;
    endfunction

    // Counter width able to hold 0..data_width
    function automatic int count_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/multiplier_4_bit_datapath.sv
// rtl/multiplier_4_bit_datapath.sv - operand shift registers, adder, accumulator and step counter
module multiplier_4_bit_datapath
    import multiplier_4_bit_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 load,
    input  logic                                 step,
    input  logic [DATA_WIDTH-1:0]                data_a,
    input  logic [DATA_WIDTH-1:0]                data_b,
    output logic [product_width(DATA_WIDTH)-1:0] sum,
    output logic                                 last
);

    localparam int PW = product_width(DATA_WIDTH);
    localparam int CW = count_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

    logic [PW-1:0]         a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [PW-1:0]         acc;
    logic [CW-1:0]         count;

    // Partial sum including this step's contribution; the top samples it on the final step
    always_comb begin
        sum = acc;
        if (b_reg[0]) begin
            sum = acc + a_reg;
        end
    end

    assign last = (count == LAST_COUNT);

    // Load operands on start, then shift A left / B right and accumulate one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            a_reg <= {{DATA_WIDTH{1'b0}}, data_a};
            b_reg <= data_b;
            acc   <= '0;
            count <= '0;
        end else if (step) begin
            a_reg <= {a_reg[PW-2:0], 1'b0};
            b_reg <= {1'b0, b_reg[DATA_WIDTH-1:1]};
            acc   <= sum;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multiplier_4_bit.sv
// rtl/multiplier_4_bit.sv - sequential unsigned shift-add multiplier with start/busy/done handshake
module multiplier_4_bit
    import multiplier_4_bit_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                                 Clock_In,
    input  logic                                 Reset_N_In,
    input  logic                                 Start_In,
    input  logic [DATA_WIDTH-1:0]                Data_A_In,
    input  logic [DATA_WIDTH-1:0]                Data_B_In,
    output logic                                 Busy_Out,
    output logic                                 Done_Out,
    output logic [product_width(DATA_WIDTH)-1:0] Multiplied_Result_Out
);

    localparam int PW = product_width(DATA_WIDTH);

    mult_state_t   state;
    logic          load;
    logic          step;
    logic [PW-1:0] sum;
    logic          last;

    // Start is only honoured while idle, so a request during RUN is simply dropped
    assign load = (state == IDLE) && Start_In;
    assign step = (state == RUN);

    multiplier_4_bit_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .clk    (Clock_In),
        .rst_n  (Reset_N_In),
        .load   (load),
        .step   (step),
        .data_a (Data_A_In),
        .data_b (Data_B_In),
        .sum    (sum),
        .last   (last)
    );

    // Control FSM with registered busy/done/result; the result only updates on completion
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state                 <= IDLE;
            Busy_Out              <= 1'b0;
            Done_Out              <= 1'b0;
            Multiplied_Result_Out <= '0;
        end else begin
            Done_Out <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start_In) begin
                        state    <= RUN;
                        Busy_Out <= 1'b1;
                    end
                end
                RUN: begin
                    if (last) begin
                        state                 <= IDLE;
                        Busy_Out              <= 1'b0;
                        Done_Out              <= 1'b1;
                        Multiplied_Result_Out <= sum;
                    end
                end
                default: begin
                    state    <= IDLE;
                    Busy_Out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_4_bit.sv
// tb/tb_multiplier_4_bit.sv - directed self-checking bench for the shift-add multiplier
module tb_multiplier_4_bit;

    localparam int W = 4;

    logic           Clock_In;
    logic           Reset_N_In;
    logic           Start_In;
    logic [W-1:0]   Data_A_In;
    logic [W-1:0]   Data_B_In;
    logic           Busy_Out;
    logic           Done_Out;
    logic [2*W-1:0] Multiplied_Result_Out;

    int             tests_run;
    int             failures;
    logic [2*W-1:0] held;
    int             done_count;

    multiplier_4_bit #(
        .DATA_WIDTH (W)
    ) dut (
        .Clock_In              (Clock_In),
        .Reset_N_In            (Reset_N_In),
        .Start_In              (Start_In),
        .Data_A_In             (Data_A_In),
        .Data_B_In             (Data_B_In),
        .Busy_Out              (Busy_Out),
        .Done_Out              (Done_Out),
        .Multiplied_Result_Out (Multiplied_Result_Out)
    );

    initial Clock_In = 1'b0;
    always #5 Clock_In = ~Clock_In;

    task automatic tick();
        @(posedge Clock_In);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE and follow it cycle by cycle; returns in the Done cycle
    task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input string tag);
        Start_In  = 1'b1;
        Data_A_In = a;
        Data_B_In = b;
        tick();
        Start_In = 1'b0;
        for (int c = 0; c < W - 1; c++) begin
            check({tag, "_busy"}, 16'(Busy_Out), 16'd1);
            check({tag, "_nodone"}, 16'(Done_Out), 16'd0);
            check({tag, "_held"}, 16'(Multiplied_Result_Out), 16'(held));
            tick();
        end
        check({tag, "_busy_last"}, 16'(Busy_Out), 16'd1);
        tick();
        check({tag, "_done"}, 16'(Done_Out), 16'd1);
        check({tag, "_idle"}, 16'(Busy_Out), 16'd0);
        check({tag, "_result"}, 16'(Multiplied_Result_Out), 16'(exp));
        held = exp;
    endtask

    initial begin
        tests_run  = 0;
        failures   = 0;
        held       = '0;
        done_count = 0;
        Reset_N_In = 1'b1;
        Start_In   = 1'b0;
        Data_A_In  = '0;
        Data_B_In  = '0;

        // Reset state
        #2 Reset_N_In = 1'b0;
        #2;
        check("rst_busy", 16'(Busy_Out), 16'd0);
        check("rst_done", 16'(Done_Out), 16'd0);
        check("rst_result", 16'(Multiplied_Result_Out), 16'h00);
        tick();
        tick();
        Reset_N_In = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("quiet_busy", 16'(Busy_Out), 16'd0);
            check("quiet_done", 16'(Done_Out), 16'd0);
        end

        // Basic and corner products
        do_mult(4'd3, 4'd5, 8'd15, "basic_3x5");
        tick();
        check("done_one_cycle", 16'(Done_Out), 16'd0);
        check("result_holds", 16'(Multiplied_Result_Out), 16'd15);
        do_mult(4'd15, 4'd15, 8'd225, "c_15x15");
        tick();
        do_mult(4'd0, 4'd9, 8'd0, "c_0x9");
        tick();
        do_mult(4'd1, 4'd15, 8'd15, "c_1x15");
        tick();
        do_mult(4'd8, 4'd2, 8'd16, "c_8x2");
        tick();

        // Start during RUN is ignored and input changes do not disturb the operation
        Start_In  = 1'b1;
        Data_A_In = 4'd7;
        Data_B_In = 4'd6;
        tick();
        Start_In  = 1'b0;
        tick();
        Start_In  = 1'b1;
        Data_A_In = 4'd2;
        Data_B_In = 4'd2;
        tick();
        Data_A_In = 4'd13;
        Data_B_In = 4'd11;
        tick();
        Start_In = 1'b0;
        tick();
        check("ign_done", 16'(Done_Out), 16'd1);
        check("ign_result", 16'(Multiplied_Result_Out), 16'd42);
        done_count = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (Done_Out) done_count++;
        end
        check("ign_single_done", 16'(done_count), 16'd0);
        check("ign_result_kept", 16'(Multiplied_Result_Out), 16'd42);
        held = 8'd42;

        // Back-to-back: second start in the Done cycle
        do_mult(4'd5, 4'd5, 8'd25, "b2b_first");
        do_mult(4'd12, 4'd11, 8'd132, "b2b_second");
        tick();

        // Reset mid-operation aborts without a Done pulse
        Start_In  = 1'b1;
        Data_A_In = 4'd9;
        Data_B_In = 4'd9;
        tick();
        Start_In = 1'b0;
        tick();
        tick();
        Reset_N_In = 1'b0;
        #1;
        check("abort_busy", 16'(Busy_Out), 16'd0);
        check("abort_done", 16'(Done_Out), 16'd0);
        check("abort_result", 16'(Multiplied_Result_Out), 16'd0);
        tick();
        tick();
        Reset_N_In = 1'b1;
        done_count = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (Done_Out) done_count++;
        end
        check("abort_no_done", 16'(done_count), 16'd0);
        held = '0;
        do_mult(4'd9, 4'd9, 8'd81, "after_abort");
        tick();

        // Exhaustive sweep against the arithmetic reference
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                Start_In  = 1'b1;
                Data_A_In = 4'(a);
                Data_B_In = 4'(b);
                tick();
                Start_In = 1'b0;
                for (int c = 0; c < W; c++) tick();
                check("sweep_done", 16'(Done_Out), 16'd1);
                check($sformatf("sweep_%0dx%0d", a, b), 16'(Multiplied_Result_Out), 16'(a * b));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/multiplier_4_bit.md
Name: multiplier_4_bit

Overview:
- Sequential unsigned shift-add multiplier: two DATA_WIDTH-bit operands in, one 2*DATA_WIDTH-bit product out.
- Operands are captured on a start strobe; the product is available DATA_WIDTH clocks later with a one-cycle done pulse.
- Arithmetic leaf block used by datapath/ALU modules that can tolerate multi-cycle latency in exchange for small area.

Parameters:
- DATA_WIDTH, 4, operand width in bits; product is 2*DATA_WIDTH; legal range 2..16.

Ports:
- Clock_In  input  1  system clock, all state on rising edge.
- Reset_N_In  input  1  asynchronous, active-low reset.
- Start_In  input  1  request; sampled only while idle.
- Data_A_In  input  DATA_WIDTH  multiplicand, unsigned.
- Data_B_In  input  DATA_WIDTH  multiplier, unsigned.
- Busy_Out  output  1  high while a multiplication is in progress.
- Done_Out  output  1  one-cycle pulse: product valid and freshly updated.
- Multiplied_Result_Out  output  2*DATA_WIDTH  product Data_A_In*Data_B_In (unsigned, exact, no overflow possible).

Behaviour:
- Reset (Reset_N_In low, asynchronous): state IDLE; Busy_Out=0, Done_Out=0, Multiplied_Result_Out=0; accumulator, operand registers, counter cleared.
- Reset asserted mid-operation aborts it immediately; no Done_Out is produced for the aborted request.
- FSM states: IDLE, RUN.
  - IDLE: on an edge with Start_In=1, capture A and B into internal registers, clear accumulator, counter=0, go to RUN. Start_In=0: stay.
  - RUN: each edge, if LSB of shifted B register is 1 add shifted A register to accumulator; shift A left by 1, B right by 1; counter++. On the DATA_WIDTH-th RUN edge, write final accumulator into Multiplied_Result_Out, assert Done_Out for the following cycle, return to IDLE.
- Latency: Start captured at edge t0 -> Done_Out high and result valid in the cycle after edge t0+DATA_WIDTH (4 cycles for default).
- Busy_Out = (state==RUN); registered, high from t0 through t0+DATA_WIDTH.
- Start_In while Busy_Out=1 is ignored (not queued). Operand changes after capture have no effect on the running operation.
- Back-to-back: Start_In high in the Done_Out cycle (state IDLE) is accepted; throughput one product per DATA_WIDTH+1 cycles.
- Multiplied_Result_Out holds its last value until the next completion; it never shows partial sums.
- Done_Out deasserts automatically after one cycle.
- Zero operands: full latency still applies (no early exit); result 0.

Decomposition:
- Shared package: state enum type (IDLE, RUN), localparam for product width (2*DATA_WIDTH) and counter width ($clog2(DATA_WIDTH+1)).
- One natural sub-module: multiplier_4_bit_datapath (operand shift registers, adder, accumulator, counter), controlled by the FSM in the top.

Test Plan:
- Reset: hold Reset_N_In low -> Busy_Out=0, Done_Out=0, Multiplied_Result_Out=8'h00; release, no activity without Start_In.
- Basic: A=4'd3, B=4'd5, Start pulse -> Done_Out high exactly 4 cycles after capture edge, result 8'd15; Busy_Out high for 4 cycles.
- Corners: A=15,B=15 -> 8'd225; A=0,B=9 -> 0; A=1,B=15 -> 15; A=8,B=2 -> 16; full 16x16 exhaustive sweep vs. reference model A*B.
- Busy/ignore: start A=7,B=6, during RUN pulse Start with A=2,B=2 and change inputs -> result 8'd42, only one Done_Out.
- Back-to-back: Start asserted in Done_Out cycle with A=12,B=11 -> first result held until second Done_Out, then 8'd132.
- Reset mid-op: start A=9,B=9, assert Reset_N_In after 2 RUN cycles -> outputs 0 immediately, no Done_Out; next request A=9,B=9 -> 8'd81.
